// File: rtl/alu_rs.sv
// ALU reservation station: operands wait for CDB broadcasts, lowest ready slot issues each cycle.
// Optional macro RS_WAKE_BYPASS_EN: a slot may issue in the same cycle its last operand is broadcast.
module alu_rs #(
    parameter int RS_SIZE = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clr_in,
    input  logic        disp_ok,
    input  logic [5:0]  disp_opt,
    input  logic [31:0] disp_vj,
    input  logic [31:0] disp_vk,
    input  logic        disp_rj,
    input  logic        disp_rk,
    input  logic [3:0]  disp_qj,
    input  logic [3:0]  disp_qk,
    input  logic [31:0] disp_imm,
    input  logic [3:0]  disp_rob,
    input  logic        cdb1_ok,
    input  logic [3:0]  cdb1_en,
    input  logic [31:0] cdb1_val,
    input  logic        cdb2_ok,
    input  logic [3:0]  cdb2_en,
    input  logic [31:0] cdb2_val,
    output logic        rs_full,
    output logic        iss_ok,
    output logic [5:0]  iss_opt,
    output logic [31:0] iss_rs1,
    output logic [31:0] iss_rs2,
    output logic [31:0] iss_imm,
    output logic [3:0]  iss_en
);
    localparam int IW = $clog2(RS_SIZE);

    typedef struct packed {
        logic        busy;
        logic [5:0]  opt;
        logic [31:0] vj;
        logic        rj;
        logic [3:0]  qj;
        logic [31:0] vk;
        logic        rk;
        logic [3:0]  qk;
        logic [31:0] imm;
        logic [3:0]  rob;
    } entry_t;

    // Returns {hit, value}; cdb1 has priority when both buses carry the tag.
    function automatic logic [32:0] snoop(input logic [3:0] tag,
                                          input logic ok1, input logic [3:0] en1, input logic [31:0] v1,
                                          input logic ok2, input logic [3:0] en2, input logic [31:0] v2);
        if (ok1 && en1 == tag) return {1'b1, v1};
        if (ok2 && en2 == tag) return {1'b1, v2};
        return 33'd0;
    endfunction

    entry_t             ent_q [RS_SIZE];
    entry_t             ent_d [RS_SIZE];
    logic [32:0]        snp_j [RS_SIZE];
    logic [32:0]        snp_k [RS_SIZE];
    logic [RS_SIZE-1:0] elig;
    logic [RS_SIZE-1:0] busy_d;
    logic [IW-1:0]      sel_idx;
    logic [IW-1:0]      free_idx;
    logic               sel_found;
    logic               do_iss;
    logic               do_disp;
    logic [32:0]        snp_dj;
    logic [32:0]        snp_dk;
    logic [31:0]        sel_vj;
    logic [31:0]        sel_vk;
    entry_t             new_ent;

    logic        rs_full_q;
    logic        iss_ok_q;
    logic [5:0]  iss_opt_q;
    logic [31:0] iss_rs1_q;
    logic [31:0] iss_rs2_q;
    logic [31:0] iss_imm_q;
    logic [3:0]  iss_en_q;

    // Dispatch handshake: disp_ok is taken at an edge only if rs_full (registered,
    // as seen at cycle start) is low, rdy_in is high and clr_in is low; a refused
    // request is dropped, not held. Issue is a pure valid pulse with no back-pressure.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        free_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            snp_j[i] = snoop(ent_q[i].qj, cdb1_ok, cdb1_en, cdb1_val, cdb2_ok, cdb2_en, cdb2_val);
            snp_k[i] = snoop(ent_q[i].qk, cdb1_ok, cdb1_en, cdb1_val, cdb2_ok, cdb2_en, cdb2_val);
`ifdef RS_WAKE_BYPASS_EN
            elig[i] = ent_q[i].busy && (ent_q[i].rj || snp_j[i][32]) && (ent_q[i].rk || snp_k[i][32]);
`else
            elig[i] = ent_q[i].busy && ent_q[i].rj && ent_q[i].rk;
`endif
            if (elig[i]) begin
                sel_idx   = IW'(i);
                sel_found = 1'b1;
            end
            if (!ent_q[i].busy) free_idx = IW'(i);
        end

        do_iss  = sel_found && rdy_in && !clr_in;
        do_disp = disp_ok && !rs_full_q && rdy_in && !clr_in;

        sel_vj = ent_q[sel_idx].vj;
        sel_vk = ent_q[sel_idx].vk;
`ifdef RS_WAKE_BYPASS_EN
        if (!ent_q[sel_idx].rj) sel_vj = snp_j[sel_idx][31:0];
        if (!ent_q[sel_idx].rk) sel_vk = snp_k[sel_idx][31:0];
`endif

        snp_dj       = snoop(disp_qj, cdb1_ok, cdb1_en, cdb1_val, cdb2_ok, cdb2_en, cdb2_val);
        snp_dk       = snoop(disp_qk, cdb1_ok, cdb1_en, cdb1_val, cdb2_ok, cdb2_en, cdb2_val);
        new_ent.busy = 1'b1;
        new_ent.opt  = disp_opt;
        new_ent.imm  = disp_imm;
        new_ent.rob  = disp_rob;
        new_ent.qj   = disp_qj;
        new_ent.qk   = disp_qk;
        new_ent.rj   = disp_rj || snp_dj[32];
        new_ent.rk   = disp_rk || snp_dk[32];
        new_ent.vj   = (!disp_rj && snp_dj[32]) ? snp_dj[31:0] : disp_vj;
        new_ent.vk   = (!disp_rk && snp_dk[32]) ? snp_dk[31:0] : disp_vk;

        for (int i = 0; i < RS_SIZE; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].busy && !ent_q[i].rj && snp_j[i][32]) begin
                ent_d[i].rj = 1'b1;
                ent_d[i].vj = snp_j[i][31:0];
            end
            if (ent_q[i].busy && !ent_q[i].rk && snp_k[i][32]) begin
                ent_d[i].rk = 1'b1;
                ent_d[i].vk = snp_k[i][31:0];
            end
            if (do_iss && sel_idx == IW'(i)) ent_d[i].busy = 1'b0;
            if (do_disp && free_idx == IW'(i)) ent_d[i] = new_ent;
            if (clr_in) ent_d[i].busy = 1'b0;
            busy_d[i] = ent_d[i].busy;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
            rs_full_q <= 1'b0;
            iss_ok_q  <= 1'b0;
            iss_opt_q <= '0;
            iss_rs1_q <= '0;
            iss_rs2_q <= '0;
            iss_imm_q <= '0;
            iss_en_q  <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
            rs_full_q <= &busy_d;
            iss_ok_q  <= do_iss;
            if (do_iss) begin
                iss_opt_q <= ent_q[sel_idx].opt;
                iss_rs1_q <= sel_vj;
                iss_rs2_q <= sel_vk;
                iss_imm_q <= ent_q[sel_idx].imm;
                iss_en_q  <= ent_q[sel_idx].rob;
            end
        end
    end

    assign rs_full = rs_full_q;
    assign iss_ok  = iss_ok_q;
    assign iss_opt = iss_opt_q;
    assign iss_rs1 = iss_rs1_q;
    assign iss_rs2 = iss_rs2_q;
    assign iss_imm = iss_imm_q;
    assign iss_en  = iss_en_q;
endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed vector table, corner-case sequences, then random traffic vs a slot model.
module tb_alu_rs;
    localparam int N = 8;
`ifdef RS_WAKE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic rst, rdy, clr, dok;
        logic [5:0] opt;
        logic [31:0] vj, vk;
        logic rj, rk;
        logic [3:0] qj, qk;
        logic [31:0] imm;
        logic [3:0] rob;
        logic c1ok; logic [3:0] c1en; logic [31:0] c1v;
        logic c2ok; logic [3:0] c2en; logic [31:0] c2v;
    } in_t;

    typedef struct packed {
        logic ok, full, cd;
        logic [5:0] opt;
        logic [31:0] rs1, rs2, imm;
        logic [3:0] en;
    } exp_t;

    typedef struct packed { in_t in; exp_t ex; } vec_t;

    typedef struct packed {
        logic busy;
        logic [5:0] opt;
        logic [31:0] vj, vk, imm;
        logic rj, rk;
        logic [3:0] qj, qk, rob;
    } slot_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_in, rdy_in, clr_in, disp_ok, disp_rj, disp_rk, cdb1_ok, cdb2_ok;
    logic [5:0] disp_opt;
    logic [31:0] disp_vj, disp_vk, disp_imm, cdb1_val, cdb2_val;
    logic [3:0] disp_qj, disp_qk, disp_rob, cdb1_en, cdb2_en;
    logic rs_full, iss_ok;
    logic [5:0] iss_opt;
    logic [31:0] iss_rs1, iss_rs2, iss_imm;
    logic [3:0] iss_en;

    alu_rs #(.RS_SIZE(N)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
        .disp_ok(disp_ok), .disp_opt(disp_opt), .disp_vj(disp_vj), .disp_vk(disp_vk),
        .disp_rj(disp_rj), .disp_rk(disp_rk), .disp_qj(disp_qj), .disp_qk(disp_qk),
        .disp_imm(disp_imm), .disp_rob(disp_rob),
        .cdb1_ok(cdb1_ok), .cdb1_en(cdb1_en), .cdb1_val(cdb1_val),
        .cdb2_ok(cdb2_ok), .cdb2_en(cdb2_en), .cdb2_val(cdb2_val),
        .rs_full(rs_full), .iss_ok(iss_ok), .iss_opt(iss_opt), .iss_rs1(iss_rs1),
        .iss_rs2(iss_rs2), .iss_imm(iss_imm), .iss_en(iss_en)
    );

    int n_vec = 0;
    int n_err = 0;
    slot_t m [N];
    exp_t mo;
    vec_t tbl [14];

    function automatic in_t nop();
        in_t x;
        x = '0;
        x.rdy = 1'b1;
        return x;
    endfunction

    function automatic in_t dsp(input int opt, input int vj, input logic rj, input int qj,
                                input int vk, input logic rk, input int qk, input int rob);
        in_t x;
        x = nop();
        x.dok = 1'b1; x.opt = 6'(opt); x.vj = 32'(vj); x.rj = rj; x.qj = 4'(qj);
        x.vk = 32'(vk); x.rk = rk; x.qk = 4'(qk); x.rob = 4'(rob);
        x.imm = 32'h1000 + 32'(rob);
        return x;
    endfunction

    function automatic in_t on1(input in_t b, input int tag, input int val);
        b.c1ok = 1'b1; b.c1en = 4'(tag); b.c1v = 32'(val);
        return b;
    endfunction

    function automatic in_t on2(input in_t b, input int tag, input int val);
        b.c2ok = 1'b1; b.c2en = 4'(tag); b.c2v = 32'(val);
        return b;
    endfunction

    function automatic exp_t ex(input logic ok, input logic full, input logic cd, input int opt,
                                input int rs1, input int rs2, input int en);
        exp_t e;
        e.ok = ok; e.full = full; e.cd = cd; e.opt = 6'(opt);
        e.rs1 = 32'(rs1); e.rs2 = 32'(rs2); e.en = 4'(en);
        e.imm = 32'h1000 + 32'(en);
        return e;
    endfunction

    // Broadcast lookup: {hit, value}, the ALU bus taking priority.
    function automatic logic [32:0] bus_val(input in_t x, input logic [3:0] tag);
        if (x.c1ok && x.c1en == tag) return {1'b1, x.c1v};
        if (x.c2ok && x.c2en == tag) return {1'b1, x.c2v};
        return 33'd0;
    endfunction

    task automatic model_step(input in_t x);
        int pick, slot;
        logic [32:0] bj, bk;
        if (x.rst) begin
            for (int i = 0; i < N; i++) m[i] = '0;
            mo = '0;
            mo.cd = 1'b1;
            return;
        end
        if (x.clr) begin
            for (int i = 0; i < N; i++) m[i].busy = 1'b0;
            mo.ok = 1'b0;
            mo.full = 1'b0;
            return;
        end
        pick = -1;
        slot = -1;
        for (int i = 0; i < N; i++) begin
            bj = bus_val(x, m[i].qj);
            bk = bus_val(x, m[i].qk);
            if (pick < 0 && m[i].busy && (m[i].rj || (BYP && bj[32])) && (m[i].rk || (BYP && bk[32])))
                pick = i;
            if (slot < 0 && !m[i].busy) slot = i;
        end
        mo.ok = x.rdy && pick >= 0;
        if (mo.ok) begin
            bj = bus_val(x, m[pick].qj);
            bk = bus_val(x, m[pick].qk);
            mo.opt = m[pick].opt;
            mo.rs1 = m[pick].rj ? m[pick].vj : bj[31:0];
            mo.rs2 = m[pick].rk ? m[pick].vk : bk[31:0];
            mo.imm = m[pick].imm;
            mo.en = m[pick].rob;
            m[pick].busy = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            bj = bus_val(x, m[i].qj);
            bk = bus_val(x, m[i].qk);
            if (m[i].busy && !m[i].rj && bj[32]) begin m[i].rj = 1'b1; m[i].vj = bj[31:0]; end
            if (m[i].busy && !m[i].rk && bk[32]) begin m[i].rk = 1'b1; m[i].vk = bk[31:0]; end
        end
        if (x.rdy && x.dok && !mo.full && slot >= 0) begin
            bj = bus_val(x, x.qj);
            bk = bus_val(x, x.qk);
            m[slot].busy = 1'b1; m[slot].opt = x.opt; m[slot].imm = x.imm; m[slot].rob = x.rob;
            m[slot].qj = x.qj; m[slot].qk = x.qk;
            m[slot].rj = x.rj || bj[32];
            m[slot].rk = x.rk || bk[32];
            m[slot].vj = (!x.rj && bj[32]) ? bj[31:0] : x.vj;
            m[slot].vk = (!x.rk && bk[32]) ? bk[31:0] : x.vk;
        end
        mo.full = 1'b1;
        for (int i = 0; i < N; i++) if (!m[i].busy) mo.full = 1'b0;
    endtask

    task automatic tick(input in_t x);
        rst_in = x.rst; rdy_in = x.rdy; clr_in = x.clr; disp_ok = x.dok;
        disp_opt = x.opt; disp_vj = x.vj; disp_vk = x.vk; disp_rj = x.rj; disp_rk = x.rk;
        disp_qj = x.qj; disp_qk = x.qk; disp_imm = x.imm; disp_rob = x.rob;
        cdb1_ok = x.c1ok; cdb1_en = x.c1en; cdb1_val = x.c1v;
        cdb2_ok = x.c2ok; cdb2_en = x.c2en; cdb2_val = x.c2v;
        model_step(x);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input exp_t e);
        logic bad;
        n_vec++;
        bad = (iss_ok !== e.ok) || (rs_full !== e.full);
        if (e.cd)
            bad = bad || (iss_opt !== e.opt) || (iss_rs1 !== e.rs1) || (iss_rs2 !== e.rs2)
                      || (iss_imm !== e.imm) || (iss_en !== e.en);
        if (bad) begin
            n_err++;
            $display("FAIL %s: got ok=%0b full=%0b opt=%0d rs1=%0h rs2=%0h imm=%0h en=%0d; want ok=%0b full=%0b opt=%0d rs1=%0h rs2=%0h imm=%0h en=%0d (data checked=%0b)",
                     name, iss_ok, rs_full, iss_opt, iss_rs1, iss_rs2, iss_imm, iss_en,
                     e.ok, e.full, e.opt, e.rs1, e.rs2, e.imm, e.en, e.cd);
        end
    endtask

    initial begin
        in_t x;
        exp_t z;
        int thr;
        z = '0;
        z.cd = 1'b1;

        tbl[0].in = nop();  tbl[0].in.rst = 1'b1;          tbl[0].ex = z;
        tbl[1].in = dsp(1, 5, 1, 0, 7, 1, 0, 3);            tbl[1].ex = ex(0, 0, 0, 0, 0, 0, 0);
        tbl[2].in = nop();                                  tbl[2].ex = ex(1, 0, 1, 1, 5, 7, 3);
        tbl[3].in = nop();                                  tbl[3].ex = ex(0, 0, 1, 1, 5, 7, 3);
        tbl[4].in = dsp(2, 0, 0, 2, 1, 1, 0, 4);            tbl[4].ex = ex(0, 0, 0, 0, 0, 0, 0);
        tbl[5].in = nop();                                  tbl[5].ex = ex(0, 0, 0, 0, 0, 0, 0);
        tbl[6].in = on1(nop(), 2, 9);                       tbl[6].ex = ex(BYP, 0, BYP, 2, 9, 1, 4);
        tbl[7].in = nop();                                  tbl[7].ex = ex(!BYP, 0, 1, 2, 9, 1, 4);
        tbl[8].in = on2(on1(dsp(3, 0, 0, 6, 11, 1, 0, 7), 6, 1), 6, 2);
        tbl[8].ex = ex(0, 0, 0, 0, 0, 0, 0);
        tbl[9].in = nop();                                  tbl[9].ex = ex(1, 0, 1, 3, 1, 11, 7);
        tbl[10].in = dsp(4, 20, 1, 0, 21, 1, 0, 8); tbl[10].in.rdy = 1'b0;
        tbl[10].ex = ex(0, 0, 1, 3, 1, 11, 7);
        tbl[11].in = nop();                                 tbl[11].ex = ex(0, 0, 1, 3, 1, 11, 7);
        tbl[12].in = dsp(5, 30, 1, 0, 31, 1, 0, 9); tbl[12].in.clr = 1'b1;
        tbl[12].ex = ex(0, 0, 1, 3, 1, 11, 7);
        tbl[13].in = nop();                                 tbl[13].ex = ex(0, 0, 1, 3, 1, 11, 7);

        for (int i = 0; i < 14; i++) begin
            tick(tbl[i].in);
            check($sformatf("tbl%0d", i), tbl[i].ex);
        end

        // Fill every slot waiting on tag 5, drop one extra request, then drain in index order.
        x = nop(); x.rst = 1'b1;
        tick(x);
        check("rst2", z);
        for (int k = 0; k < N; k++) begin
            tick(dsp(k, 0, 0, 5, 100 + k, 1, 0, k));
            check($sformatf("fill%0d", k), ex(0, k == N - 1, 0, 0, 0, 0, 0));
        end
        tick(dsp(9, 1, 1, 0, 2, 1, 0, 15));
        check("drop", ex(0, 1, 0, 0, 0, 0, 0));
        tick(on2(nop(), 5, 4));
        check("wake_all", ex(BYP, !BYP, BYP, 0, 4, 100, 0));
        for (int k = (BYP ? 1 : 0); k < N; k++) begin
            tick(nop());
            check($sformatf("drain%0d", k), ex(1, 0, 1, k, 4, 100 + k, k));
        end
        tick(nop());
        check("drain_end", ex(0, 0, 1, N - 1, 4, 100 + N - 1, N - 1));

        // Wakeup captured while stalled, issued once ready returns.
        x = nop(); x.rst = 1'b1;
        tick(x);
        tick(dsp(10, 0, 0, 9, 3, 1, 0, 2));
        check("stall_disp", ex(0, 0, 0, 0, 0, 0, 0));
        x = on1(nop(), 9, 77); x.rdy = 1'b0;
        tick(x);
        check("stall_wake", ex(0, 0, 0, 0, 0, 0, 0));
        x = nop(); x.rdy = 1'b0;
        tick(x);
        check("stall_hold", ex(0, 0, 0, 0, 0, 0, 0));
        tick(nop());
        check("stall_issue", ex(1, 0, 1, 10, 77, 3, 2));

        // Three pending slots, two stalled cycles, then a flush: nothing may issue.
        for (int k = 0; k < 3; k++) begin
            tick(dsp(11, 0, 0, 10, 1, 1, 0, k));
            check($sformatf("pend%0d", k), ex(0, 0, 0, 0, 0, 0, 0));
        end
        x = on1(nop(), 10, 55); x.rdy = 1'b0;
        tick(x);
        check("flush_stall0", ex(0, 0, 0, 0, 0, 0, 0));
        x = nop(); x.rdy = 1'b0;
        tick(x);
        check("flush_stall1", ex(0, 0, 0, 0, 0, 0, 0));
        x = nop(); x.rdy = 1'b0; x.clr = 1'b1;
        tick(x);
        check("flush", ex(0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            tick(nop());
            check($sformatf("post_flush%0d", k), ex(0, 0, 1, 10, 77, 3, 2));
        end

        // Random traffic against the slot model; bus activity alternates sparse/busy to reach full.
        x = nop(); x.rst = 1'b1;
        tick(x);
        check("rst3", mo);
        for (int c = 0; c < 1500; c++) begin
            thr = ((c % 200) < 100) ? 1 : 4;
            x = nop();
            x.rdy = ($urandom_range(0, 9) != 0);
            x.clr = ($urandom_range(0, 59) == 0);
            x.dok = ($urandom_range(0, 9) < 6);
            x.opt = 6'($urandom_range(0, 63));
            x.vj = $urandom(); x.vk = $urandom(); x.imm = $urandom();
            x.rj = 1'($urandom_range(0, 1)); x.rk = 1'($urandom_range(0, 1));
            x.qj = 4'($urandom_range(0, 3)); x.qk = 4'($urandom_range(0, 3));
            x.rob = 4'($urandom_range(0, 15));
            x.c1ok = ($urandom_range(0, 9) < thr); x.c1en = 4'($urandom_range(0, 3)); x.c1v = $urandom();
            x.c2ok = ($urandom_range(0, 9) < thr); x.c2en = 4'($urandom_range(0, 3)); x.c2v = $urandom();
            tick(x);
            check($sformatf("rand%0d", c), mo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter RS_SIZE, default 8, number of station entries; power of two, 2..16.
REQ-002 clk_in  input  1  system clock; all state updates on rising edge.
REQ-003 rst_in  input  1  synchronous, active-high reset.
REQ-004 rdy_in  input  1  global ready; low = stall.
REQ-005 clr_in  input  1  pipeline flush on branch mispredict.
REQ-006 disp_ok  input  1  dispatch request.
REQ-007 disp_opt  input  6  operation code, same encoding as the ALU.
REQ-008 disp_vj, disp_vk  input  32 each  operand values; valid when the matching ready bit is 1.
REQ-009 disp_rj, disp_rk  input  1 each  operand ready flags.
REQ-010 disp_qj, disp_qk  input  4 each  producer ROB tags; valid when the matching ready bit is 0.
REQ-011 disp_imm  input  32  immediate.
REQ-012 disp_rob  input  4  destination ROB tag.
REQ-013 cdb1_ok, cdb1_en, cdb1_val  input  1/4/32  ALU broadcast bus (valid, tag, value).
REQ-014 cdb2_ok, cdb2_en, cdb2_val  input  1/4/32  load/store broadcast bus (valid, tag, value).
REQ-015 rs_full  output  1  registered; no free entry.
REQ-016 iss_ok  output  1  registered; issue valid.
REQ-017 iss_opt  output  6  registered; issued operation code.
REQ-018 iss_rs1, iss_rs2  output  32 each  registered; issued operand values.
REQ-019 iss_imm  output  32  registered; issued immediate.
REQ-020 iss_en  output  4  registered; issued destination ROB tag; feeds the ALU en input.

Function
REQ-021 Entry state: busy, opt, vj, rj, qj, vk, rk, qk, imm, rob.
REQ-022 Dispatch: if disp_ok and not rs_full, write the lowest-index entry that is free at cycle start; set busy.
REQ-023 disp_ok while rs_full is high: request ignored, no state change.
REQ-024 Same-cycle dispatch capture: a dispatched operand with r=0 whose q equals a valid CDB tag in that cycle is stored with r=1 and the CDB value.
REQ-025 Wakeup: every busy entry with r=0 and q matching a valid CDB tag stores the value and sets r=1 at the edge.
REQ-026 Tag matching both CDBs at once: cdb1 value wins.
REQ-027 Select: each cycle, the lowest-index busy entry with rj=rk=1 is chosen; at the edge its fields are loaded into the iss_* outputs, iss_ok=1, and the entry is freed.
REQ-028 No eligible entry: iss_ok=0 at the next edge; other iss_* outputs hold.
REQ-029 Throughput: one issue per cycle. A freed slot is reusable by dispatch in the cycle after the freeing edge.
REQ-030 Latency: dispatch with both operands ready at edge N -> iss_ok=1 after edge N+1.
REQ-031 rs_full is computed from post-edge occupancy: it equals 1 when every entry is busy after that edge's dispatch and issue.
REQ-032 rdy_in=0: entries and rs_full hold; iss_ok cleared to 0; CDB wakeups still captured.
REQ-033 clr_in=1 (any rdy_in value): all entries freed, iss_ok=0, rs_full=0 at the edge; dispatch ignored that cycle.
REQ-034 Precedence: rst_in > clr_in > rdy_in.

Reset
REQ-035 On rst_in: all busy=0, rs_full=0, iss_ok=0, iss_opt=0, iss_rs1=0, iss_rs2=0, iss_imm=0, iss_en=0.

Configuration
REQ-036 Macro RS_WAKE_BYPASS_EN, defined: an entry whose last pending operand matches a valid CDB in cycle N is eligible in cycle N. The CDB value is forwarded into iss_rs1/iss_rs2, and the entry's normal wakeup write is suppressed because it is freed.
REQ-037 Macro RS_WAKE_BYPASS_EN, undefined: eligibility is evaluated on stored r bits only; a woken entry becomes eligible in cycle N+1.

Verification
REQ-038 Scenario: rst; dispatch ADD vj=5 vk=7 rob=3, both ready -> one cycle later iss_ok=1, iss_rs1=5, iss_rs2=7, iss_en=3; iss_ok=0 the cycle after.
REQ-039 Scenario: dispatch SUB rj=0 qj=2 and vk=1; cdb1 ok, en=2, val=9 two cycles later -> issue iss_rs1=9, iss_rs2=1; with RS_WAKE_BYPASS_EN, iss_ok on the edge after the CDB cycle; without it, one cycle later.
REQ-040 Scenario: dispatch RS_SIZE entries, all waiting on tag 5 -> rs_full=1; a ninth disp_ok is dropped; cdb2 en=5, val=4 -> RS_SIZE consecutive issues in index order, then rs_full=0 after the first issue edge.
REQ-041 Scenario: cdb1 and cdb2 both en=6 (val 1 and 2) in the same cycle as dispatch of an entry with qj=6 -> entry issues with iss_rs1=1.
REQ-042 Scenario: 3 entries pending and rdy_in=0 for 2 cycles, then clr_in=1 -> iss_ok=0 throughout, rs_full=0; no issue after the flush.
